// File: rtl/bcd_number_lexer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_number_lexer_pkg
// Description : Shared types and constants for the JSON number lexer.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_number_lexer_pkg;

    typedef logic [3:0] BcdDigit;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SIGN       = 4'd1,
        INT_FIRST  = 4'd2,
        INT_ZERO   = 4'd3,
        INT        = 4'd4,
        FRAC_FIRST = 4'd5,
        FRAC       = 4'd6,
        EXP_SIGN   = 4'd7,
        EXP_FIRST  = 4'd8,
        EXP        = 4'd9,
        DONE       = 4'd10,
        ERROR      = 4'd11
    } LexState;

    localparam logic [2:0] FIELD_INT  = 3'b001;
    localparam logic [2:0] FIELD_FRAC = 3'b010;
    localparam logic [2:0] FIELD_EXP  = 3'b100;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_LOW_E = 8'h65;
    localparam logic [7:0] ASCII_UP_E  = 8'h45;

endpackage
`default_nettype wire

// File: rtl/bcd_number_lexer_ascii_char_classifier.sv
`default_nettype none
// ============================================================================
// Module      : ascii_char_classifier
// Description : Combinational classification of one ASCII character into the
//               JSON number character classes plus its BCD digit value.
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_char_classifier
    import bcd_number_lexer_pkg::*;
(
    input  logic [7:0] charIn,
    output logic       isDigit,
    output logic       isDot,
    output logic       isExp,
    output logic       isPlus,
    output logic       isMinus,
    output BcdDigit    digitValue
);

    assign isDigit = (charIn >= ASCII_0) && (charIn <= ASCII_9);
    assign isDot   = (charIn == ASCII_DOT);
    assign isExp   = (charIn == ASCII_LOW_E) || (charIn == ASCII_UP_E);
    assign isPlus  = (charIn == ASCII_PLUS);
    assign isMinus = (charIn == ASCII_MINUS);

    // '0'..'9' occupy 0x30..0x39, so the low nibble is the digit value
    assign digitValue = charIn[3:0];

endmodule
`default_nettype wire

// File: rtl/bcd_number_lexer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_number_lexer
// Description : Validates one JSON number token and emits its digits as BCD
//               with a one-hot field select (integer/fraction/exponent).
// Build macro : BCD_LEXER_STRICT_EN enables leading-zero and digit-overflow
//               errors; otherwise excess digits are silently dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_number_lexer
    import bcd_number_lexer_pkg::*;
#(
    parameter int MAX_DIGITS = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] charIn,
    input  logic       charValid,
    output logic       charReady,
    input  logic       start,
    output logic       accClear,
    output BcdDigit    curDigit,
    output logic [2:0] selectedArray,
    output logic       digitEnb,
    output logic       mantNegative,
    output logic       expNegative,
    output logic       numberDone,
    output logic       numberError
);

    localparam logic [4:0] c_max_digits = 5'(MAX_DIGITS);

    if (MAX_DIGITS < 1 || MAX_DIGITS > 31) begin : g_max_digits_check
        $error("MAX_DIGITS must be within 1..31");
    end

    logic    w_is_digit;
    logic    w_is_dot;
    logic    w_is_exp;
    logic    w_is_plus;
    logic    w_is_minus;
    BcdDigit w_digit;

    ascii_char_classifier u_classifier (
        .charIn     (charIn),
        .isDigit    (w_is_digit),
        .isDot      (w_is_dot),
        .isExp      (w_is_exp),
        .isPlus     (w_is_plus),
        .isMinus    (w_is_minus),
        .digitValue (w_digit)
    );

    LexState    r_state;
    logic [4:0] r_cnt_int;
    logic [4:0] r_cnt_frac;
    logic [4:0] r_cnt_exp;
    logic       r_acc_clear;
    BcdDigit    r_cur_digit;
    logic [2:0] r_selected_array;
    logic       r_digit_enb;
    logic       r_mant_negative;
    logic       r_exp_negative;
    logic       r_number_done;
    logic       r_number_error;

    LexState    w_next;
    logic [2:0] w_field;
    logic       w_take;
    logic       w_terminate;
    logic       w_set_mneg;
    logic       w_set_eneg;
    logic [4:0] w_field_cnt;
    logic       w_full;
    logic       w_emit;
    logic       w_active;
    logic       w_accept;

    // Decode of the current character against the current state
    always_comb begin
        w_next      = r_state;
        w_field     = FIELD_INT;
        w_take      = 1'b0;
        w_terminate = 1'b0;
        w_set_mneg  = 1'b0;
        w_set_eneg  = 1'b0;
        w_field_cnt = r_cnt_int;
        case (r_state)
            SIGN, INT_FIRST: begin
                if (r_state == SIGN && w_is_minus) begin
                    w_set_mneg = 1'b1;
                    w_next     = INT_FIRST;
                end else if (w_is_digit) begin
                    w_take = 1'b1;
                    w_next = (w_digit == 4'd0) ? INT_ZERO : INT;
                end else begin
                    w_next = ERROR;
                end
            end
            INT_ZERO, INT: begin
                if (w_is_digit) begin
`ifdef BCD_LEXER_STRICT_EN
                    if (r_state == INT_ZERO) begin
                        w_next = ERROR;
                    end else begin
                        w_take = 1'b1;
                        w_next = INT;
                    end
`else
                    w_take = 1'b1;
                    w_next = INT;
`endif
                end else if (w_is_dot) begin
                    w_next = FRAC_FIRST;
                end else if (w_is_exp) begin
                    w_next = EXP_SIGN;
                end else begin
                    w_terminate = 1'b1;
                end
            end
            FRAC_FIRST: begin
                w_field = FIELD_FRAC;
                if (w_is_digit) begin
                    w_take = 1'b1;
                    w_next = FRAC;
                end else begin
                    w_next = ERROR;
                end
            end
            FRAC: begin
                w_field = FIELD_FRAC;
                if (w_is_digit) begin
                    w_take = 1'b1;
                end else if (w_is_exp) begin
                    w_next = EXP_SIGN;
                end else begin
                    w_terminate = 1'b1;
                end
            end
            EXP_SIGN: begin
                w_field = FIELD_EXP;
                if (w_is_plus) begin
                    w_next = EXP_FIRST;
                end else if (w_is_minus) begin
                    w_set_eneg = 1'b1;
                    w_next     = EXP_FIRST;
                end else if (w_is_digit) begin
                    w_take = 1'b1;
                    w_next = EXP;
                end else begin
                    w_next = ERROR;
                end
            end
            EXP_FIRST: begin
                w_field = FIELD_EXP;
                if (w_is_digit) begin
                    w_take = 1'b1;
                    w_next = EXP;
                end else begin
                    w_next = ERROR;
                end
            end
            EXP: begin
                w_field = FIELD_EXP;
                if (w_is_digit) begin
                    w_take = 1'b1;
                end else begin
                    w_terminate = 1'b1;
                end
            end
            default: ;
        endcase

        case (w_field)
            FIELD_FRAC: w_field_cnt = r_cnt_frac;
            FIELD_EXP:  w_field_cnt = r_cnt_exp;
            default:    w_field_cnt = r_cnt_int;
        endcase
        w_full = (w_field_cnt >= c_max_digits);
        w_emit = w_take & ~w_full;
`ifdef BCD_LEXER_STRICT_EN
        if (w_take && w_full) begin
            w_next = ERROR;
        end
`endif
    end

    assign w_active  = !(r_state inside {IDLE, DONE, ERROR});
    // The terminator is left on the bus for the token parser, so never ready for it
    assign charReady = w_active & ~start & ~w_terminate;
    assign w_accept  = charValid & charReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_cnt_int        <= 5'd0;
            r_cnt_frac       <= 5'd0;
            r_cnt_exp        <= 5'd0;
            r_acc_clear      <= 1'b0;
            r_cur_digit      <= 4'd0;
            r_selected_array <= 3'b000;
            r_digit_enb      <= 1'b0;
            r_mant_negative  <= 1'b0;
            r_exp_negative   <= 1'b0;
            r_number_done    <= 1'b0;
            r_number_error   <= 1'b0;
        end else begin
            r_acc_clear   <= 1'b0;
            r_digit_enb   <= 1'b0;
            r_number_done <= 1'b0;
            if (start) begin
                r_state         <= SIGN;
                r_cnt_int       <= 5'd0;
                r_cnt_frac      <= 5'd0;
                r_cnt_exp       <= 5'd0;
                r_mant_negative <= 1'b0;
                r_exp_negative  <= 1'b0;
                r_number_error  <= 1'b0;
                r_acc_clear     <= 1'b1;
            end else if (w_accept) begin
                r_state <= w_next;
                if (w_next == ERROR) begin
                    r_number_error <= 1'b1;
                end
                if (w_set_mneg) begin
                    r_mant_negative <= 1'b1;
                end
                if (w_set_eneg) begin
                    r_exp_negative <= 1'b1;
                end
                if (w_emit) begin
                    r_digit_enb      <= 1'b1;
                    r_cur_digit      <= w_digit;
                    r_selected_array <= w_field;
                    case (w_field)
                        FIELD_FRAC: r_cnt_frac <= r_cnt_frac + 5'd1;
                        FIELD_EXP:  r_cnt_exp  <= r_cnt_exp + 5'd1;
                        default:    r_cnt_int  <= r_cnt_int + 5'd1;
                    endcase
                end
            end else if (charValid && w_terminate) begin
                r_number_done <= 1'b1;
                r_state       <= DONE;
            end
        end
    end

    assign accClear      = r_acc_clear;
    assign curDigit      = r_cur_digit;
    assign selectedArray = r_selected_array;
    assign digitEnb      = r_digit_enb;
    assign mantNegative  = r_mant_negative;
    assign expNegative   = r_exp_negative;
    assign numberDone    = r_number_done;
    assign numberError   = r_number_error;

endmodule
`default_nettype wire

// File: tb/tb_bcd_number_lexer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_number_lexer
// Description : Self-checking bench for bcd_number_lexer; a grammar-level
//               token parser predicts digits, flags and consumption.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_number_lexer;

    localparam int MAX_DIGITS = 19;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] charIn;
    logic       charValid;
    logic       charReady;
    logic       start;
    logic       accClear;
    logic [3:0] curDigit;
    logic [2:0] selectedArray;
    logic       digitEnb;
    logic       mantNegative;
    logic       expNegative;
    logic       numberDone;
    logic       numberError;

    always #5 clk = ~clk;

    bcd_number_lexer #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .charIn        (charIn),
        .charValid     (charValid),
        .charReady     (charReady),
        .start         (start),
        .accClear      (accClear),
        .curDigit      (curDigit),
        .selectedArray (selectedArray),
        .digitEnb      (digitEnb),
        .mantNegative  (mantNegative),
        .expNegative   (expNegative),
        .numberDone    (numberDone),
        .numberError   (numberError)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] tok[$];
    int         got_q[$];
    int         exp_q[$];
    int         done_cnt;
    bit         collect = 1'b0;
    int         got_cons;
    bit         got_acc;
    bit         got_err0;
    bit         timed_out;

    // Reference results: expected digits encoded as field*16+digit
    int         m_q[$];
    int         m_cons;
    bit         m_err, m_mneg, m_eneg;

    logic [7:0] alpha [16] = '{"0", "1", "5", "9", ".", "e", "E", "+",
                               "-", ",", "]", " ", "x", "0", "7", "}"};
    logic [7:0] terms [4]  = '{" ", ",", "]", "}"};

    always @(negedge clk) begin
        if (collect) begin
            if (digitEnb) got_q.push_back(int'({selectedArray, curDigit}));
            if (numberDone) done_cnt++;
        end
    end

    function automatic string qstr(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic logic [7:0] at(input int p);
        return (p < tok.size()) ? tok[p] : 8'h20;
    endfunction

    function automatic bit isd(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    task automatic load(input string s);
        tok.delete();
        for (int i = 0; i < s.len(); i++) tok.push_back(s[i]);
    endtask

    // Consume a run of digits for one field, applying the per-field digit limit
    task automatic model_run(input int field, input bit int_part, inout int p, output bit bad);
        int n = 0;
        logic [7:0] first = at(p);
        bad = 1'b0;
        while (isd(at(p))) begin
`ifdef BCD_LEXER_STRICT_EN
            if ((int_part && n == 1 && first == "0") || n == MAX_DIGITS) begin
                bad = 1'b1;
                p++;
                return;
            end
`else
            if (int_part && first == 8'h00) bad = 1'b0;
`endif
            if (n < MAX_DIGITS) m_q.push_back(field * 16 + int'(at(p) - "0"));
            n++;
            p++;
        end
    endtask

    task automatic model();
        int p = 0;
        bit bad;
        m_q.delete();
        m_err = 1'b0; m_mneg = 1'b0; m_eneg = 1'b0;
        if (at(p) == "-") begin m_mneg = 1'b1; p++; end
        if (!isd(at(p))) begin m_err = 1'b1; m_cons = p + 1; return; end
        model_run(1, 1'b1, p, bad);
        if (bad) begin m_err = 1'b1; m_cons = p; return; end
        if (at(p) == ".") begin
            p++;
            if (!isd(at(p))) begin m_err = 1'b1; m_cons = p + 1; return; end
            model_run(2, 1'b0, p, bad);
            if (bad) begin m_err = 1'b1; m_cons = p; return; end
        end
        if (at(p) == "e" || at(p) == "E") begin
            p++;
            if (at(p) == "-") begin m_eneg = 1'b1; p++; end
            else if (at(p) == "+") p++;
            if (!isd(at(p))) begin m_err = 1'b1; m_cons = p + 1; return; end
            model_run(4, 1'b0, p, bad);
            if (bad) begin m_err = 1'b1; m_cons = p; return; end
        end
        m_cons = p;
    endtask

    // Start a number, feed tok until the lexer stops accepting, then let pulses drain
    task automatic run_token();
        int idx = 0;
        int cycles = 0;
        got_q.delete();
        done_cnt  = 0;
        timed_out = 1'b0;
        collect   = 1'b1;
        @(negedge clk);
        start = 1'b1; charValid = 1'b0;
        @(negedge clk);
        got_acc  = accClear;
        got_err0 = numberError;
        start = 1'b0;
        while (idx < tok.size()) begin
            if (cycles > 300) begin timed_out = 1'b1; break; end
            cycles++;
            if ($urandom_range(0, 3) == 0) begin
                charValid = 1'b0;
                charIn = 8'($urandom);
                @(negedge clk);
                continue;
            end
            charIn = tok[idx]; charValid = 1'b1;
            #1;
            if (!charReady) break;
            @(negedge clk);
            idx++;
        end
        got_cons = idx;
        repeat (4) @(negedge clk);
        charValid = 1'b0;
        @(negedge clk);
        collect = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; charValid = 1'b1; charIn = "5";
        repeat (2) @(negedge clk);
        n_tests++;
        if ({charReady, accClear, digitEnb, curDigit, selectedArray, mantNegative,
             expNegative, numberDone, numberError} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b acc=%b enb=%b dig=%h sel=%b mn=%b en=%b done=%b err=%b, expected all 0",
                     charReady, accClear, digitEnb, curDigit, selectedArray, mantNegative,
                     expNegative, numberDone, numberError);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (charReady !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got %b expected 0", charReady);
        end
        charValid = 1'b0;
    endtask

    task automatic test_signed_exponent();
        load("-12.5e+3,");
        run_token();
        exp_q = '{'h11, 'h12, 'h25, 'h43};
        n_tests++; if (got_acc !== 1'b1) begin n_fail++; $display("FAIL acc_clear: got %b expected 1", got_acc); end
        n_tests++; if (qstr(got_q) != qstr(exp_q)) begin n_fail++; $display("FAIL signed_digits: got %s expected %s", qstr(got_q), qstr(exp_q)); end
        n_tests++; if (mantNegative !== 1'b1 || expNegative !== 1'b0) begin n_fail++; $display("FAIL signed_flags: got mn=%b en=%b expected mn=1 en=0", mantNegative, expNegative); end
        n_tests++; if (done_cnt != 1 || got_cons != 8) begin n_fail++; $display("FAIL signed_done: got done=%0d consumed=%0d expected done=1 consumed=8", done_cnt, got_cons); end
    endtask

    task automatic test_zero_exponent();
        load("0e-7 ");
        run_token();
        exp_q = '{'h10, 'h47};
        n_tests++; if (qstr(got_q) != qstr(exp_q)) begin n_fail++; $display("FAIL zero_exp_digits: got %s expected %s", qstr(got_q), qstr(exp_q)); end
        n_tests++; if (expNegative !== 1'b1 || mantNegative !== 1'b0) begin n_fail++; $display("FAIL zero_exp_flags: got mn=%b en=%b expected mn=0 en=1", mantNegative, expNegative); end
        n_tests++; if (done_cnt != 1 || numberError !== 1'b0) begin n_fail++; $display("FAIL zero_exp_done: got done=%0d err=%b expected done=1 err=0", done_cnt, numberError); end
    endtask

    task automatic test_leading_zero();
        int exp_done;
        bit exp_err;
        load("01 ");
        run_token();
`ifdef BCD_LEXER_STRICT_EN
        exp_q = '{'h10}; exp_done = 0; exp_err = 1'b1;
`else
        exp_q = '{'h10, 'h11}; exp_done = 1; exp_err = 1'b0;
`endif
        n_tests++; if (qstr(got_q) != qstr(exp_q)) begin n_fail++; $display("FAIL lead_zero_digits: got %s expected %s", qstr(got_q), qstr(exp_q)); end
        n_tests++; if (numberError !== exp_err || done_cnt != exp_done) begin n_fail++; $display("FAIL lead_zero_status: got err=%b done=%0d expected err=%b done=%0d", numberError, done_cnt, exp_err, exp_done); end
    endtask

    task automatic test_missing_fraction();
        load("1.]");
        run_token();
        exp_q = '{'h11};
        n_tests++; if (qstr(got_q) != qstr(exp_q)) begin n_fail++; $display("FAIL frac_missing_digits: got %s expected %s", qstr(got_q), qstr(exp_q)); end
        n_tests++; if (numberError !== 1'b1 || done_cnt != 0) begin n_fail++; $display("FAIL frac_missing_status: got err=%b done=%0d expected err=1 done=0", numberError, done_cnt); end
        n_tests++; if (charReady !== 1'b0) begin n_fail++; $display("FAIL error_ready: got %b expected 0", charReady); end
    endtask

    task automatic test_overflow();
        int exp_done;
        bit exp_err;
        tok.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) tok.push_back("9");
        tok.push_back(" ");
        for (int i = 0; i < MAX_DIGITS; i++) exp_q.push_back('h19);
        run_token();
`ifdef BCD_LEXER_STRICT_EN
        exp_done = 0; exp_err = 1'b1;
`else
        exp_done = 1; exp_err = 1'b0;
`endif
        n_tests++; if (got_err0 !== 1'b0) begin n_fail++; $display("FAIL start_clears_error: got %b expected 0", got_err0); end
        n_tests++; if (qstr(got_q) != qstr(exp_q)) begin n_fail++; $display("FAIL overflow_digits: got %0d digits expected %0d", got_q.size(), exp_q.size()); end
        n_tests++; if (numberError !== exp_err || done_cnt != exp_done || got_cons != 20) begin n_fail++; $display("FAIL overflow_status: got err=%b done=%0d consumed=%0d expected err=%b done=%0d consumed=20", numberError, done_cnt, got_cons, exp_err, exp_done); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; charValid = 1'b0;
        @(negedge clk);
        start = 1'b0; charIn = "1"; charValid = 1'b1;
        @(negedge clk);
        charIn = "2";
        @(posedge clk); #1;
        n_tests++;
        if (digitEnb !== 1'b1 || curDigit !== 4'd2) begin
            n_fail++;
            $display("FAIL pre_reset_digit: got enb=%b dig=%h expected enb=1 dig=2", digitEnb, curDigit);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({charReady, accClear, digitEnb, curDigit, selectedArray, mantNegative,
             expNegative, numberDone, numberError} !== 14'h0) begin
            n_fail++;
            $display("FAIL async_reset: got ready=%b enb=%b dig=%h sel=%b done=%b err=%b expected all 0",
                     charReady, digitEnb, curDigit, selectedArray, numberDone, numberError);
        end
        @(negedge clk);
        charValid = 1'b0; rst = 1'b0;
        load("7 ");
        run_token();
        exp_q = '{'h17};
        n_tests++; if (qstr(got_q) != qstr(exp_q)) begin n_fail++; $display("FAIL after_reset_digits: got %s expected %s", qstr(got_q), qstr(exp_q)); end
        n_tests++; if (done_cnt != 1 || got_cons != 1) begin n_fail++; $display("FAIL after_reset_done: got done=%0d consumed=%0d expected done=1 consumed=1", done_cnt, got_cons); end
    endtask

    task automatic gen_digits(input int lo, input int hi);
        int n = $urandom_range(lo, hi);
        for (int i = 0; i < n; i++) tok.push_back(8'("0" + $urandom_range(0, 9)));
    endtask

    task automatic test_random();
        for (int t = 0; t < 80; t++) begin
            tok.delete();
            if ($urandom_range(0, 1) == 1) tok.push_back("-");
            if ($urandom_range(0, 6) == 0) gen_digits(18, 22); else gen_digits(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                tok.push_back(".");
                if ($urandom_range(0, 6) == 0) gen_digits(18, 22); else gen_digits(1, 3);
            end
            if ($urandom_range(0, 2) == 0) begin
                tok.push_back(($urandom_range(0, 1) == 1) ? 8'h65 : 8'h45);
                case ($urandom_range(0, 2))
                    0: tok.push_back("+");
                    1: tok.push_back("-");
                    default: ;
                endcase
                if ($urandom_range(0, 6) == 0) gen_digits(18, 22); else gen_digits(1, 2);
            end
            tok.push_back(terms[$urandom_range(0, 3)]);
            if ($urandom_range(0, 2) == 0) tok[$urandom_range(0, tok.size() - 2)] = alpha[$urandom_range(0, 15)];
            model();
            run_token();
            n_tests++; if (timed_out) begin n_fail++; $display("FAIL rnd%0d_timeout: got no stop expected stop after %0d chars", t, m_cons); end
            n_tests++; if (got_acc !== 1'b1 || got_err0 !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_start: got acc=%b err=%b expected acc=1 err=0", t, got_acc, got_err0); end
            n_tests++; if (got_cons != m_cons) begin n_fail++; $display("FAIL rnd%0d_consumed: got %0d expected %0d", t, got_cons, m_cons); end
            n_tests++; if (numberError !== m_err) begin n_fail++; $display("FAIL rnd%0d_error: got %b expected %b", t, numberError, m_err); end
            n_tests++; if (done_cnt != (m_err ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_done: got %0d expected %0d", t, done_cnt, m_err ? 0 : 1); end
            n_tests++; if (mantNegative !== m_mneg || expNegative !== m_eneg) begin n_fail++; $display("FAIL rnd%0d_flags: got mn=%b en=%b expected mn=%b en=%b", t, mantNegative, expNegative, m_mneg, m_eneg); end
            n_tests++; if (qstr(got_q) != qstr(m_q)) begin n_fail++; $display("FAIL rnd%0d_digits: got %s expected %s", t, qstr(got_q), qstr(m_q)); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; charValid = 1'b0; charIn = 8'h00;
        test_reset();
        test_signed_exponent();
        test_zero_exponent();
        test_leading_zero();
        test_missing_fraction();
        test_overflow();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_number_lexer.md
Name: bcd_number_lexer

Overview:
- Upstream feeder of the three-field BCD accumulator.
- Consumes a stream of ASCII characters belonging to one JSON number token, validates the JSON number grammar and strips sign, '.', 'e'/'E'.
- Emits one BCD digit per cycle with a one-hot field select: bit0 integer, bit1 fraction, bit2 exponent. Also reports sign flags and done/error status to the token-level parser.

Parameters:
- MAX_DIGITS, 19, maximum digits accepted per field (64-bit accumulator limit); must be ≤31 to fit the 5-bit digit count.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- charIn  input  8  ASCII character
- charValid  input  1  charIn valid
- charReady  output  1  block accepts charIn this cycle
- start  input  1  pulse: a new number begins with the next accepted char
- accClear  output  1  one-cycle pulse to the accumulator reset, issued the cycle after start
- curDigit  output  4  Bcd::BcdDigit, registered
- selectedArray  output  3  one-hot field select, registered
- digitEnb  output  1  curDigit/selectedArray valid this cycle
- mantNegative  output  1  leading '-' seen
- expNegative  output  1  exponent '-' seen
- numberDone  output  1  one-cycle pulse, number legally terminated
- numberError  output  1  sticky until next start, grammar or overflow error

Behaviour:
- Reset: state IDLE. All outputs 0 except charReady=0. Digit counters 0.
- Handshake: a char is accepted when charValid & charReady. charReady=1 in every state except IDLE, DONE and ERROR.
- start in IDLE/DONE/ERROR:
  - go to SIGN
  - clear flags and counters
  - accClear=1 next cycle
  - numberError cleared
- start in any other state aborts the current number with the same effect. No numberDone is issued.
- States and transitions on accepted char:
  - SIGN: '-' sets mantNegative, goes to INT_FIRST. A digit is handled as in INT_FIRST. Anything else → ERROR.
  - INT_FIRST: '0' → INT_ZERO; '1'-'9' → INT; else ERROR.
  - INT_ZERO: '.' → FRAC_FIRST; 'e'/'E' → EXP_SIGN; digit → ERROR (leading zero); other → terminate.
  - INT: digit → INT; '.' → FRAC_FIRST; 'e'/'E' → EXP_SIGN; other → terminate.
  - FRAC_FIRST: digit → FRAC; else ERROR.
  - FRAC: digit → FRAC; 'e'/'E' → EXP_SIGN; other → terminate.
  - EXP_SIGN: '+' → EXP_FIRST; '-' sets expNegative, → EXP_FIRST; digit → EXP; else ERROR.
  - EXP_FIRST: digit → EXP; else ERROR.
  - EXP: digit → EXP; other → terminate.
- Digit output: every accepted digit appears exactly 1 cycle later:
  - digitEnb=1
  - curDigit=char-'0'
  - selectedArray = field of the state that accepted it
- Terminate:
  - The terminating char is NOT consumed; charReady=0 in the same cycle (combinational on charIn class).
  - numberDone pulses next cycle, then state DONE.
  - The terminator stays for the token parser.
- Overflow: the (MAX_DIGITS+1)th digit in any field → ERROR, and that digit is not emitted.
- ERROR: numberError=1, charReady=0, digitEnb=0 until start.
- No char accepted while charValid=0; state holds.
- Async rst mid-number returns to IDLE immediately. No pending digitEnb or numberDone survives.

Optional Feature:
- Macro: BCD_LEXER_STRICT_EN.
- Defined: leading-zero rule (INT_ZERO digit → ERROR) and MAX_DIGITS overflow check are enforced.
- Undefined:
  - INT_ZERO behaves as INT.
  - Digits past MAX_DIGITS are accepted and not emitted (dropped silently).
  - numberError only for structural errors.

Decomposition:
- Bcd package:
  - lexer state enum (LexState)
  - field one-hot constants FIELD_INT=3'b001, FIELD_FRAC=3'b010, FIELD_EXP=3'b100
  - ASCII constants for '0','9','-','+','.','e','E'
- Sub-module ascii_char_classifier (combinational): charIn → isDigit, isDot, isExp, isPlus, isMinus, digit value.

Test Plan:
- start, "-12.5e+3" then ',':
  - digits 1,2 sel 001; 5 sel 010; 3 sel 100
  - mantNegative=1, expNegative=0
  - numberDone 1 cycle after ',' is presented; ',' not consumed (charReady=0).
- start, "0e-7 ": digits 0 (001), 7 (100); expNegative=1; numberDone.
- start, "01": numberError after '1', no digit for '1'. Without BCD_LEXER_STRICT_EN: digits 0,1 sel 001, no error.
- start, "1." then ']': numberError (FRAC_FIRST non-digit), numberDone never pulses.
- start, 20 × '9' with MAX_DIGITS=19: 19 digitEnb pulses, then numberError. The 20th is not emitted.
- rst asserted after "12" accepted: all outputs 0 within the cycle. A following start, "7 " gives a single digit 7 sel 001 and numberDone.
